// File: rtl/time_lock_seq.sv
// Multi-stage time-lock sequencer: timed stages, each passed by a confirm inside the late-stage window.
// Optional macro TIME_LOCK_RETRY_EN lets a failed stage restart up to MAX_RETRIES times per sequence.
module time_lock_seq #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned DWELL       = 6,
    parameter int unsigned WINDOW      = 2,
    parameter int unsigned MAX_RETRIES = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               confirm,
    output logic [$clog2(NUM_STAGES+1)-1:0]    stage_code,
    output logic                               window_open,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic                               lock_done,
    output logic                               lock_fail
);

    localparam int unsigned SW = $clog2(NUM_STAGES + 1);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned TW = $clog2(DWELL);

    localparam logic [TW-1:0] T_LAST  = TW'(DWELL - 1);
    localparam logic [TW-1:0] T_WIN   = TW'(DWELL - WINDOW);
    localparam logic [SW-1:0] S_LAST  = SW'(NUM_STAGES);
`ifdef TIME_LOCK_RETRY_EN
    localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRIES);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [SW-1:0]   stage_q;
    logic [RW-1:0]   retry_q;
    logic            done_q;
    logic            fail_q;
    logic            win_open;

    assign win_open = (state_q == S_RUN) && (timer_q >= T_WIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            stage_q <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (abort) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            stage_q <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (start && (state_q != S_RUN)) begin
            state_q <= S_RUN;
            timer_q <= '0;
            stage_q <= SW'(1);
            retry_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (state_q == S_RUN) begin
            if (confirm && win_open) begin
                if (stage_q < S_LAST) begin
                    stage_q <= stage_q + 1'b1;
                    timer_q <= '0;
                end else begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end else if (confirm || (timer_q == T_LAST)) begin
                // Early press or expired window; timer stays frozen on entry to FAIL.
`ifdef TIME_LOCK_RETRY_EN
                if (retry_q < R_MAX) begin
                    retry_q <= retry_q + 1'b1;
                    timer_q <= '0;
                end else begin
                    state_q <= S_FAIL;
                    fail_q  <= 1'b1;
                end
`else
                state_q <= S_FAIL;
                fail_q  <= 1'b1;
`endif
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign stage_code  = stage_q;
    assign window_open = win_open;
    assign retry_cnt   = retry_q;
    assign lock_done   = done_q;
    assign lock_fail   = fail_q;

endmodule

// File: tb/tb_time_lock_seq.sv
// Directed bench for time_lock_seq at default parameters; a vector table plus hand sequences.
// Expectations follow TIME_LOCK_RETRY_EN when the bench is built with that macro.
module tb_time_lock_seq;

`ifdef TIME_LOCK_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       confirm;
    logic [1:0] stage_code;
    logic       window_open;
    logic [1:0] retry_cnt;
    logic       lock_done;
    logic       lock_fail;

    int total = 0;
    int bad   = 0;

    time_lock_seq #(
        .NUM_STAGES (3),
        .DWELL      (6),
        .WINDOW     (2),
        .MAX_RETRIES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .confirm    (confirm),
        .stage_code (stage_code),
        .window_open(window_open),
        .retry_cnt  (retry_cnt),
        .lock_done  (lock_done),
        .lock_fail  (lock_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       a;
        logic       c;
        logic [1:0] st;
        logic       w;
        logic [1:0] rc;
        logic       d;
        logic       f;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic s, a, c, input logic [1:0] st, input logic w,
                                input logic [1:0] rc, input logic d, f);
        vec_t v;
        v.s = s; v.a = a; v.c = c;
        v.st = st; v.w = w; v.rc = rc; v.d = d; v.f = f;
        tbl.push_back(v);
    endfunction

    // Packed outputs: {stage_code, window_open, retry_cnt, lock_done, lock_fail}
    function automatic logic [6:0] pk(input logic [1:0] st, input logic w,
                                      input logic [1:0] rc, input logic d, f);
        return {st, w, rc, d, f};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {stage_code, window_open, retry_cnt, lock_done, lock_fail};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d win=%0b rc=%0d done=%0b fail=%0b, expected st=%0d win=%0b rc=%0d done=%0b fail=%0b",
                     name, got[6:5], got[4], got[3:2], got[1], got[0],
                     exp[6:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic s, a, c);
        start = s; abort = a; confirm = c;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; confirm = 1'b0;
    endtask

    // Four idle cycles then a confirm at timer==4 passes the stage.
    task automatic add_pass(input logic [1:0] st_now, input logic [1:0] st_next,
                            input logic last);
        for (int i = 1; i <= 4; i++)
            add(0, 0, 0, st_now, (i == 4), 2'd0, 0, 0);
        if (last) add(0, 0, 1, st_now, 0, 2'd0, 1, 0);
        else      add(0, 0, 1, st_next, 0, 2'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; confirm = 1'b0;

        // Full pass, hold in DONE, restart, abort mid-stage, then a stage-2 timeout.
        add(1, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        add_pass(2'd1, 2'd2, 0);
        add_pass(2'd2, 2'd3, 0);
        add_pass(2'd3, 2'd3, 1);
        add(0, 0, 1, 2'd3, 0, 2'd0, 1, 0);
        add(1, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        add_pass(2'd1, 2'd2, 0);
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 2'd2, 0, 2'd0, 0, 0);
        add(1, 1, 1, 2'd0, 0, 2'd0, 0, 0);
        add(0, 0, 1, 2'd0, 0, 2'd0, 0, 0);
        add(1, 0, 0, 2'd1, 0, 2'd0, 0, 0);
        add_pass(2'd1, 2'd2, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 2'd2, (i >= 4), 2'd0, 0, 0);
        if (RETRY) add(0, 0, 0, 2'd2, 0, 2'd1, 0, 0);
        else       add(0, 0, 0, 2'd2, 0, 2'd0, 0, 1);
        add(0, 1, 0, 2'd0, 0, 2'd0, 0, 0);

        #12;
        check("reset_state", pk(2'd0, 0, 2'd0, 0, 0));
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].a, tbl[i].c);
            check($sformatf("vec%0d", i), pk(tbl[i].st, tbl[i].w, tbl[i].rc, tbl[i].d, tbl[i].f));
        end

        // Early press at timer==1 of stage 1.
        step(1, 0, 0);
        check("early_start", pk(2'd1, 0, 2'd0, 0, 0));
        step(0, 0, 0);
        if (RETRY) begin
            step(0, 0, 1);
            check("retry_first", pk(2'd1, 0, 2'd1, 0, 0));
            step(0, 0, 1);
            check("retry_second", pk(2'd1, 0, 2'd2, 0, 0));
            step(0, 0, 1);
            check("retry_exhausted", pk(2'd1, 0, 2'd2, 0, 1));
        end else begin
            step(0, 0, 1);
            check("early_fail", pk(2'd1, 0, 2'd0, 0, 1));
        end
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        check("fail_hold", pk(2'd1, 0, RETRY ? 2'd2 : 2'd0, 0, 1));
        step(1, 0, 0);
        check("restart_from_fail", pk(2'd1, 0, 2'd0, 0, 0));

        // Asynchronous reset mid-stage clears outputs without a clock edge.
        step(0, 0, 0);
        step(0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", pk(2'd0, 0, 2'd0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0);
        check("start_after_reset", pk(2'd1, 0, 2'd0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
